// File: rtl/arbiter2_rr.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter2_rr
//  Purpose  : Two-channel round-robin arbiter with bounded grant tenure.
//             A grant is issued one cycle after a request is sampled in IDLE.
//             It is held until the holder raises done, or until it has lasted
//             HOLD_MAX cycles. A forced release produces a one-cycle timeout
//             pulse. Every release is followed by a single idle bubble.
//  Ports    : clk         - sole clock, rising edge
//             rst         - synchronous active-high reset
//             req0/req1   - level-sensitive channel requests
//             done        - holder releases the grant (only looked at in GRANT)
//             grant_valid - a grant is active this cycle
//             grant_sel   - granted channel index (decoder select, held in IDLE)
//             timeout     - one-cycle pulse after a forced release
//  Revision : 1.0 - initial release
// ============================================================================
module arbiter2_rr #(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic done,
   output logic grant_valid,
   output logic grant_sel,
   output logic timeout
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(HOLD_MAX - 1);

   state_t           state_q,    state_d;
   logic             grant_sel_q, grant_sel_d;
   logic             timeout_q,  timeout_d;
   logic             last_sel_q, last_sel_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             pick_sel;

   // On contention the channel that did not win last time is chosen; with a
   // single request that channel wins regardless of history.
   assign pick_sel = (req0 & req1) ? ~last_sel_q : req1;

   always_comb begin
      state_d     = state_q;
      grant_sel_d = grant_sel_q;
      timeout_d   = 1'b0;
      last_sel_d  = last_sel_q;
      cnt_d       = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req0 | req1) begin
               state_d     = ST_GRANT;
               grant_sel_d = pick_sel;
               last_sel_d  = pick_sel;
               cnt_d       = '0;
            end
         end
         ST_GRANT: begin
            // done wins over the tenure limit, so a coincident done never
            // reports a timeout.
            if (done) begin
               state_d = ST_IDLE;
            end else if (cnt_q == C_CNT_LAST) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_sel_q <= 1'b0;
         timeout_q   <= 1'b0;
         last_sel_q  <= 1'b1;   // first contention after reset favours channel 0
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         grant_sel_q <= grant_sel_d;
         timeout_q   <= timeout_d;
         last_sel_q  <= last_sel_d;
         cnt_q       <= cnt_d;
      end
   end

   // All outputs come straight from flops (a one-bit state flop for valid).
   assign grant_valid = (state_q == ST_GRANT);
   assign grant_sel   = grant_sel_q;
   assign timeout     = timeout_q;

endmodule
`default_nettype wire
